cu_fsm: RTL and testbench

CU_FSM -- requirements
Module: cu_fsm

---
 rtl/cu_fsm_if.sv | 36 +++
 rtl/cu_fsm.sv | 128 ++++++++++++
 tb/tb_cu_fsm.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/cu_fsm_if.sv
// Control-unit bundle between the multicycle control FSM and the datapath.
//   Instruction fields : ir6to0 (opcode), ir14to12 (func3)
//   Interrupt inputs   : intr (level request), mie (global enable from CSR file)
//   Control outputs    : PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, rst,
//                        csr_WE, int_taken, mret_exec, illegal
//   Status             : instret (retired-instruction count)
// The controller side uses the master modport; the datapath uses slave.
interface cu_fsm_if;
    logic [6:0]  ir6to0;
    logic [2:0]  ir14to12;
    logic        intr;
    logic        mie;
    logic        PCWrite;
    logic        regWrite;
    logic        memWE2;
    logic        memRDEN1;
    logic        memRDEN2;
    logic        rst;
    logic        csr_WE;
    logic        int_taken;
    logic        mret_exec;
    logic        illegal;
    logic [31:0] instret;

    modport master (
        input  ir6to0, ir14to12, intr, mie,
        output PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, rst,
               csr_WE, int_taken, mret_exec, illegal, instret
    );

    modport slave (
        output ir6to0, ir14to12, intr, mie,
        input  PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, rst,
               csr_WE, int_taken, mret_exec, illegal, instret
    );
endinterface

// File: rtl/cu_fsm.sv
// Multicycle control unit for a RISC-V style core.
//   CLK : system clock, all state changes on the rising edge
//   RST : asynchronous active-high reset
//   bus : cu_fsm_if.master -- instruction fields and interrupt request in,
//         datapath enables, interrupt handshakes and retired-instruction count out
// Each instruction takes FETCH, EXEC and (loads only) WB; an interrupt seen on
// the last cycle of an instruction inserts one INTR cycle before the next fetch.
// Control outputs decode combinationally from the current state and opcode.
module cu_fsm (
    input  logic     CLK,
    input  logic     RST,
    cu_fsm_if.master bus
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef enum logic [2:0] {
        StInit  = 3'd0,
        StFetch = 3'd1,
        StExec  = 3'd2,
        StWb    = 3'd3,
        StIntr  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;
    logic        take_intr;

    assign take_intr   = bus.intr & bus.mie;
    assign bus.instret = instret_q;

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        bus.PCWrite   = 1'b0;
        bus.regWrite  = 1'b0;
        bus.memWE2    = 1'b0;
        bus.memRDEN1  = 1'b0;
        bus.memRDEN2  = 1'b0;
        bus.rst       = 1'b0;
        bus.csr_WE    = 1'b0;
        bus.int_taken = 1'b0;
        bus.mret_exec = 1'b0;
        bus.illegal   = 1'b0;

        case (state_q)
            StInit: begin
                bus.rst = 1'b1;
                state_d = StFetch;
            end

            StFetch: begin
                bus.memRDEN1 = 1'b1;
                state_d      = StExec;
            end

            StExec: begin
                if (bus.ir6to0 == OpLoad) begin
                    bus.memRDEN2 = 1'b1;
                    state_d      = StWb;
                end else begin
                    bus.PCWrite = 1'b1;
                    retire      = 1'b1;
                    // Interrupts are only sampled on an instruction's final cycle.
                    state_d     = take_intr ? StIntr : StFetch;
                    case (bus.ir6to0)
                        OpStore:  bus.memWE2 = 1'b1;
                        OpBranch: ;
                        OpJal, OpJalr, OpReg, OpImm, OpLui, OpAuipc: bus.regWrite = 1'b1;
                        OpSystem: begin
                            case (bus.ir14to12)
                                3'b000: bus.mret_exec = 1'b1;
                                3'b001, 3'b010, 3'b011: begin
                                    bus.csr_WE   = 1'b1;
                                    bus.regWrite = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        default: bus.illegal = 1'b1;
                    endcase
                end
            end

            StWb: begin
                bus.regWrite = 1'b1;
                bus.PCWrite  = 1'b1;
                retire       = 1'b1;
                state_d      = take_intr ? StIntr : StFetch;
            end

            StIntr: begin
                bus.int_taken = 1'b1;
                bus.PCWrite   = 1'b1;
                state_d       = StFetch;
            end

            default: begin
                // Corrupted encoding: hold the PC cleared and restart cleanly.
                bus.rst = 1'b1;
                state_d = StInit;
            end
        endcase
    end

    assign instret_d = instret_q + {31'd0, retire};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StInit;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_cu_fsm.sv
// Scoreboard bench for cu_fsm: the stimulus process models each instruction as
// a list of expected cycles and queues them; a monitor compares every cycle.
module tb_cu_fsm;

    localparam int B_PCW  = 9;
    localparam int B_RW   = 8;
    localparam int B_WE2  = 7;
    localparam int B_RD1  = 6;
    localparam int B_RD2  = 5;
    localparam int B_RST  = 4;
    localparam int B_CSR  = 3;
    localparam int B_IT   = 2;
    localparam int B_MRET = 1;
    localparam int B_ILL  = 0;

    typedef struct packed {
        logic [9:0]  ctl;
        logic [31:0] instret;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    cu_fsm_if bus ();

    cu_fsm dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    exp_t        sb_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_instret = 32'd0;

    logic [6:0] ops [13] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
                             7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1110011,
                             7'b1110011, 7'b1110011, 7'b1111111};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    function automatic logic [9:0] bitv(input int b);
        logic [9:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    // Expected EXEC-cycle controls straight from the instruction-class rules.
    function automatic logic [9:0] exec_ctl(input logic [6:0] op, input logic [2:0] f3);
        logic [9:0] v;
        v = '0;
        if (op == 7'b0000011) begin
            v[B_RD2] = 1'b1;
        end else begin
            v[B_PCW] = 1'b1;
            if (op == 7'b0100011) v[B_WE2] = 1'b1;
            else if (op == 7'b1100011) v = v;
            else if (op == 7'b1101111 || op == 7'b1100111) v[B_RW] = 1'b1;
            else if (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0110111 ||
                     op == 7'b0010111) v[B_RW] = 1'b1;
            else if (op == 7'b1110011) begin
                if (f3 == 3'd0) v[B_MRET] = 1'b1;
                else if (f3 >= 3'd1 && f3 <= 3'd3) begin
                    v[B_CSR] = 1'b1;
                    v[B_RW]  = 1'b1;
                end
            end else v[B_ILL] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [9:0] act_ctl();
        return {bus.PCWrite, bus.regWrite, bus.memWE2, bus.memRDEN1, bus.memRDEN2,
                bus.rst, bus.csr_WE, bus.int_taken, bus.mret_exec, bus.illegal};
    endfunction

    task automatic push(input logic [9:0] ctl);
        exp_t e;
        e.ctl     = ctl;
        e.instret = model_instret;
        sb_q.push_back(e);
    endtask

    task automatic rand_irq();
        bus.intr = 1'($urandom_range(0, 1));
        bus.mie  = 1'($urandom_range(0, 1));
    endtask

    // Hold RST for n cycles, then release for the single INIT cycle.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            RST = 1'b1;
            model_instret = 32'd0;
            rand_irq();
            push(bitv(B_RST));
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        rand_irq();
        push(bitv(B_RST));
    endtask

    // One instruction. rnd_last=0 forces intr/mie on its final cycle;
    // preload_max seeds the retired count with all ones during FETCH.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input bit rnd_last,
                             input logic l_intr, input logic l_mie, input bit preload_max);
        bit is_load;
        bit take;
        is_load = (op == 7'b0000011);
        @(posedge CLK); #1;
        bus.ir6to0   = op;
        bus.ir14to12 = f3;
        rand_irq();
        if (preload_max) begin
            force dut.instret_q = 32'hFFFF_FFFF;
            model_instret = 32'hFFFF_FFFF;
        end
        push(bitv(B_RD1));
        @(posedge CLK); #1;
        if (preload_max) release dut.instret_q;
        rand_irq();
        if (!is_load && !rnd_last) begin
            bus.intr = l_intr;
            bus.mie  = l_mie;
        end
        take = !is_load && bus.intr && bus.mie;
        push(exec_ctl(op, f3));
        if (is_load) begin
            @(posedge CLK); #1;
            rand_irq();
            if (!rnd_last) begin
                bus.intr = l_intr;
                bus.mie  = l_mie;
            end
            take = bus.intr && bus.mie;
            push(bitv(B_RW) | bitv(B_PCW));
        end
        model_instret = model_instret + 32'd1;
        if (take) begin
            @(posedge CLK); #1;
            rand_irq();
            push(bitv(B_IT) | bitv(B_PCW));
        end
    endtask

    // Load whose WB cycle is cut short by an asynchronous reset.
    task automatic load_abort();
        @(posedge CLK); #1;
        bus.ir6to0 = 7'b0000011;
        rand_irq();
        push(bitv(B_RD1));
        @(posedge CLK); #1;
        push(exec_ctl(7'b0000011, 3'd0));
        @(posedge CLK); #1;
        chk("wb_regwrite_before_rst", {31'd0, bus.regWrite}, 32'd1);
        #1 RST = 1'b1;
        #1;
        chk("wb_regwrite_after_rst", {31'd0, bus.regWrite}, 32'd0);
        chk("wb_rst_out_after_rst", {31'd0, bus.rst}, 32'd1);
        model_instret = 32'd0;
        push(bitv(B_RST));
        do_reset(1);
    endtask

    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("ctl {PCW,RW,WE2,RD1,RD2,rst,csrWE,intT,mret,ill}", {22'd0, act_ctl()},
                {22'd0, e.ctl});
            chk("instret", bus.instret, e.instret);
        end
    end

    initial begin
        bus.ir6to0   = 7'b0010011;
        bus.ir14to12 = 3'd0;
        bus.intr     = 1'b0;
        bus.mie      = 1'b0;
        RST          = 1'b1;
        #1;
        chk("rst_async_at_start", {31'd0, bus.rst}, 32'd1);
        do_reset(3);

        // Load then add; neither takes an interrupt.
        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        // addi with interrupt enabled, then same with mie clear.
        run_instr(7'b0010011, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_instr(7'b0010011, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Interrupt after a load's WB.
        run_instr(7'b0000011, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_instr(7'b1110011, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(7'b1110011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(7'b1110011, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Counter wrap.
        run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_instr(7'b0000011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        load_abort();

        for (int n = 0; n < 400; n++) begin
            int r;
            logic [6:0] op;
            r  = int'($urandom_range(0, 15));
            op = (r < 13) ? ops[r] : 7'($urandom);
            run_instr(op, 3'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
            if ($urandom_range(0, 99) == 0) do_reset(int'($urandom_range(1, 3)));
        end

        repeat (3) @(negedge CLK);
        #1;
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
